// File: rtl/memory_cycle_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface memory_cycle_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/memory_cycle.sv
// RV32I memory stage: issues loads/stores on the req/ack bus, stalls the front
// of the pipeline while an access is outstanding, and drives the MEM/WB register.
module memory_cycle (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] MEM_alu_data,
  input  logic [31:0] MEM_rs2_data,
  input  logic [31:0] MEM_pc_four,
  input  logic [4:0]  MEM_rd_addr,
  input  logic        MEM_rd_wren,
  input  logic [8:0]  MEM_mem_en,
  input  logic [1:0]  MEM_wb_en,
  output logic [31:0] MEM_fwd_data,
  output logic        MEM_stall,
  memory_cycle_if.master dmem,
  output logic [31:0] WB_alu_data,
  output logic [31:0] WB_ld_data,
  output logic [31:0] WB_pc_four,
  output logic [4:0]  WB_rd_addr,
  output logic        WB_rd_wren,
  output logic [1:0]  WB_wb_en,
  output logic        WB_misalign
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_reg;

  logic [1:0]  off;
  logic        is_store, is_half, is_word, access, misalign, aligned, ack_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ld_next;
  logic [7:0]  rd_byte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_mem_en8;

  // Bit 8 of the access type is reserved and deliberately ignored.
  assign unused_mem_en8 = MEM_mem_en[8];

  assign off      = MEM_alu_data[1:0];
  assign is_store = |MEM_mem_en[2:0];
  assign is_half  = MEM_mem_en[1] | MEM_mem_en[4] | MEM_mem_en[7];
  assign is_word  = MEM_mem_en[2] | MEM_mem_en[5];
  assign access   = |MEM_mem_en[7:0];
  assign misalign = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign aligned  = access & ~misalign;
  assign ack_hit  = (state_reg == BUSY) & dmem.ack;

  assign MEM_fwd_data = MEM_alu_data;
  assign MEM_stall    = aligned & ~ack_hit;

  // Per byte lane: store enable, replicated store data and read-back byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be_next[gi] = is_store & (MEM_mem_en[2]
                         | (MEM_mem_en[1] & (off[1] == LANE[1]))
                         | (MEM_mem_en[0] & (off == LANE)));
      assign wdata_next[8*gi +: 8] = MEM_mem_en[2] ? MEM_rs2_data[8*gi +: 8] :
                                     MEM_mem_en[1] ? MEM_rs2_data[8*(gi%2) +: 8] :
                                                     MEM_rs2_data[7:0];
      assign rd_byte[gi] = dmem.rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rd_byte[off];
  assign half_sel = off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

  always_comb begin
    ld_next = '0;
    if (MEM_mem_en[3])      ld_next = {{24{byte_sel[7]}}, byte_sel};
    else if (MEM_mem_en[6]) ld_next = {24'b0, byte_sel};
    else if (MEM_mem_en[4]) ld_next = {{16{half_sel[15]}}, half_sel};
    else if (MEM_mem_en[7]) ld_next = {16'b0, half_sel};
    else if (MEM_mem_en[5]) ld_next = dmem.rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= '0;
      dmem.wdata  <= '0;
      dmem.be     <= '0;
      WB_alu_data <= '0;
      WB_ld_data  <= '0;
      WB_pc_four  <= '0;
      WB_rd_addr  <= '0;
      WB_rd_wren  <= 1'b0;
      WB_wb_en    <= '0;
      WB_misalign <= 1'b0;
    end else begin
      WB_alu_data <= MEM_alu_data;
      WB_pc_four  <= MEM_pc_four;
      WB_rd_addr  <= MEM_rd_addr;
      WB_ld_data  <= ack_hit ? ld_next : 32'b0;
      // A stalled instruction leaves a bubble behind it in MEM/WB.
      if (MEM_stall) begin
        WB_rd_wren  <= 1'b0;
        WB_wb_en    <= '0;
        WB_misalign <= 1'b0;
      end else begin
        WB_rd_wren  <= MEM_rd_wren & ~misalign;
        WB_wb_en    <= MEM_wb_en;
        WB_misalign <= misalign;
      end

      case (state_reg)
        IDLE: begin
          if (aligned) begin
            dmem.req   <= 1'b1;
            dmem.we    <= is_store;
            dmem.addr  <= {MEM_alu_data[31:2], 2'b00};
            dmem.be    <= be_next;
            dmem.wdata <= wdata_next;
            state_reg  <= BUSY;
          end
        end
        BUSY: begin
          if (dmem.ack) begin
            dmem.req  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
